// File: rtl/serializer_if.sv
// Word-in / bit-out handshake bundle for the serializer.
// master drives words and consumes bits; slave is the serializer itself.
interface serializer_if #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
);
    logic [DATA_W-1:0] data_i;
    logic [MOD_W-1:0]  data_mod_i;
    logic              data_val_i;
    logic              ser_data_o;
    logic              ser_data_val_o;
    logic              busy_o;

    modport master (
        output data_i,
        output data_mod_i,
        output data_val_i,
        input  ser_data_o,
        input  ser_data_val_o,
        input  busy_o
    );

    modport slave (
        input  data_i,
        input  data_mod_i,
        input  data_val_i,
        output ser_data_o,
        output ser_data_val_o,
        output busy_o
    );
endinterface

// File: rtl/serializer.sv
// Parallel-to-serial converter, MSB first, back-to-back words without gaps.
// Define SERIALIZER_LSB_FIRST_EN to send LSB first (data_i[N-1:0]).
module serializer #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
) (
    input  logic         clk_i,
    input  logic         srst_i,
    serializer_if.slave  bus
);

    typedef enum logic {IDLE, TX} state_t;

    localparam logic [MOD_W:0] FULL_CNT = (MOD_W+1)'(DATA_W);

    state_t            state_q, state_d;
    logic [MOD_W:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;

    logic              accept;
    logic              last_bit;
    logic              out_bit;
    logic [MOD_W:0]    load_cnt;
    logic [DATA_W-1:0] shifted;

    // In TX the counter holds the bits still to drive, including the current one.
    assign last_bit = (state_q == TX) && (cnt_q == (MOD_W+1)'(1));
    assign accept   = bus.data_val_i && !bus.busy_o;
    assign load_cnt = (bus.data_mod_i == '0) ? FULL_CNT
                                             : {1'b0, bus.data_mod_i};

`ifdef SERIALIZER_LSB_FIRST_EN
    assign out_bit = shreg_q[0];
    assign shifted = {1'b0, shreg_q[DATA_W-1:1]};
`else
    assign out_bit = shreg_q[DATA_W-1];
    assign shifted = {shreg_q[DATA_W-2:0], 1'b0};
`endif

    assign bus.ser_data_val_o = (state_q == TX);
    assign bus.ser_data_o     = (state_q == TX) ? out_bit : 1'b0;
    assign bus.busy_o         = (state_q == TX) && !last_bit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = TX;
                    cnt_d   = load_cnt;
                    shreg_d = bus.data_i;
                end
            end
            TX: begin
                if (accept) begin
                    cnt_d   = load_cnt;
                    shreg_d = bus.data_i;
                end else if (last_bit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    shreg_d = '0;
                end else begin
                    cnt_d   = cnt_q - (MOD_W+1)'(1);
                    shreg_d = shifted;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                shreg_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

endmodule
